// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-adder FSM states and the counter-width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } add_state_t;

  // Bit count able to hold 0..w, so that w=1 and powers of two still fit
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; the whole datapath of the bit-serial adder.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder: one bit per clock, LSB first, through a single carry flop.
// Operands enter and results leave through independent valid/ready handshakes.
module serial_adder_nbit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  add_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
  logic             fa_s, fa_cout;
  logic             last_bit;

  full_adder_1bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case
  assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ADD;
      ADD:     if (last_bit)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand/sum shift registers, carry flop and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      Sum       <= '0;
      Carry_out <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= Carry_in;
      count <= '0;
    end else if (state == ADD) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_next;
      carry  <= fa_cout;
      count  <= count + CNT_W'(1);
      if (last_bit) begin
        Sum       <= sum_next;
        Carry_out <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit at WIDTH = 4, 1 and 8 with hand-computed results.
module tb_serial_adder_nbit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, Carry_in, Carry_out;
  logic [3:0] A, B, Sum;
  logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_Carry_in, w1_Carry_out;
  logic [0:0] w1_A, w1_B, w1_Sum;
  logic       w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready, w8_Carry_in, w8_Carry_out;
  logic [7:0] w8_A, w8_B, w8_Sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_nbit #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .Carry_in(Carry_in), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum),
    .Carry_out(Carry_out)
  );

  serial_adder_nbit #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .A(w1_A), .B(w1_B),
    .Carry_in(w1_Carry_in), .out_valid(w1_out_valid), .out_ready(w1_out_ready), .Sum(w1_Sum),
    .Carry_out(w1_Carry_out)
  );

  serial_adder_nbit #(.WIDTH(8)) u_dut_w8 (
    .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .A(w8_A), .B(w8_B),
    .Carry_in(w8_Carry_in), .out_valid(w8_out_valid), .out_ready(w8_out_ready), .Sum(w8_Sum),
    .Carry_out(w8_Carry_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ov(input int w);
    case (w)
      1:       return w1_out_valid;
      8:       return w8_out_valid;
      default: return out_valid;
    endcase
  endfunction

  // Tick until out_valid of the selected instance rises (bounded); n = edges waited
  task automatic wait_valid(input int w, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ov(w) !== 1'b1 && n < 40);
    check($sformatf("w%0d_valid_seen", w), 32'(ov(w)), 32'd1);
  endtask

  task automatic do_txn(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic eco, input string tag);
    int         n;
    logic [7:0] s;
    logic       co;
    case (w)
      1: begin
        w1_A = a[0:0]; w1_B = b[0:0]; w1_Carry_in = cin; w1_out_ready = 1'b1; w1_in_valid = 1'b1;
      end
      8: begin
        w8_A = a; w8_B = b; w8_Carry_in = cin; w8_out_ready = 1'b1; w8_in_valid = 1'b1;
      end
      default: begin
        A = a[3:0]; B = b[3:0]; Carry_in = cin; out_ready = 1'b1; in_valid = 1'b1;
      end
    endcase
    tick();
    in_valid = 1'b0; w1_in_valid = 1'b0; w8_in_valid = 1'b0;
    wait_valid(w, n);
    case (w)
      1:       begin s = 8'(w1_Sum); co = w1_Carry_out; end
      8:       begin s = w8_Sum;     co = w8_Carry_out; end
      default: begin s = 8'(Sum);    co = Carry_out;    end
    endcase
    check({tag, "_lat"}, 32'(n), 32'(w));
    check({tag, "_sum"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(co), 32'(eco));
    tick();
    check({tag, "_done"}, 32'(ov(w)), 32'd0);
  endtask

  initial begin
    int n;
    int ghost;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Carry_in = 1'b0;
    w1_in_valid = 1'b0; w1_out_ready = 1'b1; w1_A = '0; w1_B = '0; w1_Carry_in = 1'b0;
    w8_in_valid = 1'b0; w8_out_ready = 1'b1; w8_A = '0; w8_B = '0; w8_Carry_in = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_cout", 32'(Carry_out), 32'd0);
    check("rst_w1_in_ready", 32'(w1_in_ready), 32'd1);
    check("rst_w8_out_valid", 32'(w8_out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    do_txn(4, 8'd4, 8'd5, 1'b0, 8'd9, 1'b0, "w4_4p5");
    do_txn(4, 8'd15, 8'd1, 1'b0, 8'd0, 1'b1, "w4_15p1");
    do_txn(4, 8'd15, 8'd15, 1'b1, 8'd15, 1'b1, "w4_15p15c1");
    repeat (3) tick();
    check("w4_sum_hold_idle", 32'(Sum), 32'd15);
    check("w4_cout_hold_idle", 32'(Carry_out), 32'd1);

    // Backpressure: 6+7 held in HOLD while a new request waits
    A = 4'd6; B = 4'd7; Carry_in = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(4, n);
    check("bp_lat", 32'(n), 32'd4);
    A = 4'd1; B = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("bp_hold_%0d", i), 32'({out_valid, in_ready, Carry_out, Sum}),
            32'(7'b1_0_0_1101));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    wait_valid(4, n);
    check("bp_next_lat", 32'(n), 32'd4);
    check("bp_next_sum", 32'(Sum), 32'd2);
    check("bp_next_cout", 32'(Carry_out), 32'd0);
    tick();

    // Reset two cycles into an addition of 7+8
    A = 4'd7; B = 4'd8; Carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sum", 32'(Sum), 32'd0);
    check("midrst_cout", 32'(Carry_out), 32'd0);
    #3;
    rst = 1'b0;
    ghost = 0;
    repeat (8) begin
      tick();
      if (out_valid) ghost++;
    end
    check("midrst_no_result", 32'(ghost), 32'd0);
    do_txn(4, 8'd3, 8'd2, 1'b0, 8'd5, 1'b0, "w4_after_rst");

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1; Carry_in = 1'b0;
    A = 4'd1; B = 4'd2; in_valid = 1'b1;
    tick();
    A = 4'd6; B = 4'd9;
    wait_valid(4, n);
    check("b2b_0_lat", 32'(n), 32'd4);
    check("b2b_0_sum", 32'(Sum), 32'd3);
    check("b2b_0_cout", 32'(Carry_out), 32'd0);
    wait_valid(4, n);
    A = 4'd10; B = 4'd10;
    check("b2b_1_spacing", 32'(n), 32'd6);
    check("b2b_1_sum", 32'(Sum), 32'd15);
    check("b2b_1_cout", 32'(Carry_out), 32'd0);
    wait_valid(4, n);
    in_valid = 1'b0;
    check("b2b_2_spacing", 32'(n), 32'd6);
    check("b2b_2_sum", 32'(Sum), 32'd4);
    check("b2b_2_cout", 32'(Carry_out), 32'd1);
    tick();
    tick();

    do_txn(1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b1, "w1_1p1");
    do_txn(1, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0, "w1_cin");
    do_txn(8, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, "w8_200p100");
    do_txn(8, 8'd255, 8'd0, 1'b1, 8'd0, 1'b1, "w8_wrap");
    do_txn(8, 8'd18, 8'd52, 1'b1, 8'd71, 1'b0, "w8_18p52c1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
Bit-serial N-bit adder. It is the sequential addition counterpart to the team's parallel ripple-borrow subtractor.
- Accepts A, B and Carry_in through a valid/ready handshake.
- Adds one bit per clock, LSB first, using a single carry flip-flop.
- Returns Sum and Carry_out through a second valid/ready handshake.
- Used where area matters more than latency, and as a cross-check model against the parallel arithmetic blocks.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands present on A, B, Carry_in
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  first operand (augend)
B  input  WIDTH  second operand (addend)
Carry_in  input  1  initial carry into bit 0
out_valid  output  1  Sum and Carry_out hold a completed result
out_ready  input  1  consumer accepts the result
Sum  output  WIDTH  result, (A + B + Carry_in) mod 2^WIDTH
Carry_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, carry FF=0, operand shift registers=0, Sum=0, Carry_out=0, out_valid=0. Reset asserted mid-operation aborts the operation; no result is produced.
- States: IDLE, ADD, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: load A and B into shift registers, load carry FF with Carry_in, set count=0, go to ADD.
- ADD:
  - in_ready=0, out_valid=0. in_valid is ignored and operands are not sampled.
  - Each cycle, s = a0 ^ b0 ^ c and c_next = majority(a0, b0, c).
  - Shift s into the MSB of the internal sum shift register. Shift both operand registers right by one. carry FF <= c_next. count++.
  - On the edge where count == WIDTH-1 (the WIDTH-th ADD cycle): load Sum from the completed sum register, load Carry_out from c_next, go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0. Sum and Carry_out are stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0 on the next cycle.
- Latency: operands accepted at edge k give out_valid=1 after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles at best.
- out_ready may be held high in advance; the handshake then completes on the first HOLD edge. out_ready is a don't-care outside HOLD.
- Sum and Carry_out change only on the ADD->HOLD edge. They hold the last result through IDLE until the next completion.
- WIDTH=1: ADD lasts exactly one cycle.
- Wrap-around: overflow beyond WIDTH bits appears only in Carry_out; Sum is modulo 2^WIDTH.
- Counter width is $clog2(WIDTH+1) so that WIDTH=1 and powers of two are covered.

Decomposition:
- Shared package arith_pkg: state typedef (enum IDLE/ADD/HOLD) and the function or constant for the counter width.
- One natural sub-module, full_adder_1bit (combinational: a, b, cin -> s, cout), instantiated once for the serial datapath.

Test Plan:
- WIDTH=4, A=4, B=5, Carry_in=0, out_ready=1 -> out_valid rises 4 cycles after accept; Sum=9, Carry_out=0.
- A=15, B=1, Carry_in=0 -> Sum=0, Carry_out=1. A=15, B=15, Carry_in=1 -> Sum=15, Carry_out=1.
- Backpressure: out_ready=0 for 6 cycles after out_valid rises -> Sum/Carry_out/out_valid stable and in_ready=0 throughout; the new in_valid with A=1, B=1 is ignored until the block returns to IDLE.
- Reset mid-ADD (rst pulse 2 cycles after accept of A=7, B=8) -> all outputs 0 and in_ready=1 immediately; no out_valid follows. Next transaction A=3, B=2 -> Sum=5.
- Back-to-back: in_valid and out_ready held high, three operand pairs (1+2, 6+9, 10+10) -> results 3/0, 15/0, 4/1, each spaced WIDTH+2 cycles.
- WIDTH=1 and WIDTH=8 builds: 1+1 -> Sum=0, Carry_out=1; 200+100 -> Sum=44, Carry_out=1; 8-bit latency is 8 cycles.
